ts_pid_capture: RTL and testbench
=================================

TS_PID_CAPTURE -- requirements
Module: ts_pid_capture

Interface
REQ-001 SHALL have parameter C_S_AXI_DATA_WIDTH, default 32, the width of the register/word bus (only 32 supported).
REQ-002 SHALL have parameter CAPTURE_PID_COUNT, default 4, the number of PID filter slots.
REQ-003 SHALL have ports: clk  in  1  sole clock; rst  in  1  reset, synchronous, active-high.
REQ-004 SHALL have ports: mpeg_data  in  8  TS byte; mpeg_valid  in  1  byte qualifier; mpeg_sync  in  1  marks packet byte 0.
REQ-005 SHALL have ports: update_pid_request  in  1; pid_index  in  32; pid  in  32 (bits 12:0 PID, bit 16 enable); out_pid  out  32  readback of slot pid_index, same layout, other bits zero.
REQ-006 SHALL have ports: arm  in  1  start hunt; capture_ack  in  1  release buffer; capture_busy  out  1; capture_done  out  1.
REQ-007 SHALL have ports: read_index  in  32  word address; read_data  out  32  buffer word; captured_pid  out  13.
REQ-008 SHALL have ports: captured_count  out  32; resync_count  out  32; cc_error_count  out  32.

Function
REQ-009 SHALL accept a byte only on a cycle with mpeg_valid=1; all stream-side state SHALL hold otherwise.
REQ-010 SHALL write a PID slot on update_pid_request=1 when pid_index < CAPTURE_PID_COUNT; out-of-range writes SHALL be ignored and out-of-range reads return 0.
REQ-011 SHALL hold one 188-byte packet in a 47x32 buffer, byte k at word k/4, bits 8*(k%4)+7 down to 8*(k%4).
REQ-012 SHALL implement states IDLE, HUNT, CAPTURE, DONE.
REQ-013 IDLE: arm=1 -> HUNT; stream ignored.
REQ-014 HUNT: accepted byte with mpeg_sync=1 and data 8'h47 -> stored as byte 0, byte counter=1, state CAPTURE; other bytes discarded.
REQ-015 CAPTURE: each accepted byte stored at counter, counter+1; after byte 2, PID={byte1[4:0],byte2} SHALL be compared against all enabled slots; no match -> HUNT.
REQ-016 CAPTURE: after byte 187 stored -> DONE; captured_pid, captured_count+1 and capture_done=1 SHALL appear the following cycle.
REQ-017 CAPTURE: accepted byte with mpeg_sync=1 at counter!=0 SHALL increment resync_count and restart per REQ-014 on that same byte (0x47 -> counter=1; otherwise HUNT).
REQ-018 DONE: stream ignored, buffer frozen; capture_ack=1 -> IDLE; capture_ack=1 and arm=1 same cycle -> HUNT.
REQ-019 arm SHALL be ignored outside IDLE/DONE; capture_ack ignored outside DONE.
REQ-020 capture_busy SHALL be 1 in HUNT and CAPTURE; capture_done SHALL be 1 only in DONE.
REQ-021 read_data SHALL be registered: word read_index one cycle after presentation; read_index >= 47 returns 0.
REQ-022 counters SHALL wrap modulo 2^32.

Reset
REQ-023 rst=1 SHALL force IDLE, clear all PID slots and enables, zero every output and counter; buffer contents SHALL be undefined.
REQ-024 rst asserted mid-capture SHALL abandon the packet with no count update.

Configuration
REQ-025 Macro TS_CAPTURE_CC_CHECK_EN defined: on each completed capture, cc_error_count SHALL increment when byte3[3:0] != (previous captured CC+1) mod 16; first capture after reset not checked.
REQ-026 Macro undefined: cc_error_count SHALL be constant 0 and no CC state SHALL be built.

Verification
REQ-027 Slot0 PID 0x100 enabled, arm, packet PID 0x100 bytes k=k%256 -> capture_done, captured_count=1, word 1 reads 32'h07060504 (byte 4 in bits 7:0).
REQ-028 Packet PID 0x101 then PID 0x100 -> first discarded, second captured, captured_pid=0x100.
REQ-029 mpeg_sync with 0x47 at byte 100 mid-capture -> resync_count=1, new packet captured from that byte.
REQ-030 mpeg_valid toggling 1/0 every cycle -> identical buffer to gapless run.
REQ-031 DONE with arm and capture_ack same cycle -> busy=1 next cycle; rst during CAPTURE -> all outputs 0.
REQ-032 With TS_CAPTURE_CC_CHECK_EN, captures with CC 3 then 5 -> cc_error_count=1; without macro -> 0.

Source files
------------

// File: rtl/ts_pid_capture_if.sv
// MPEG transport-stream byte bus: one byte per mpeg_valid cycle, mpeg_sync flags packet byte 0.
// No backpressure; the sink must accept every qualified byte.
interface ts_pid_capture_if;
  logic [7:0] mpeg_data;
  logic       mpeg_valid;
  logic       mpeg_sync;

  modport master (output mpeg_data, output mpeg_valid, output mpeg_sync);
  modport slave  (input  mpeg_data, input  mpeg_valid, input  mpeg_sync);
endinterface

// File: rtl/ts_pid_capture.sv
// Captures one 188-byte TS packet whose PID matches an enabled filter slot; read_data has 1-cycle latency.
// No backpressure: stream bytes are dropped outside HUNT/CAPTURE. Optional CC check: TS_CAPTURE_CC_CHECK_EN.
module ts_pid_capture #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int CAPTURE_PID_COUNT  = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  ts_pid_capture_if.slave               ts,
  input  logic                          update_pid_request,
  input  logic [C_S_AXI_DATA_WIDTH-1:0] pid_index,
  input  logic [C_S_AXI_DATA_WIDTH-1:0] pid,
  output logic [C_S_AXI_DATA_WIDTH-1:0] out_pid,
  input  logic                          arm,
  input  logic                          capture_ack,
  output logic                          capture_busy,
  output logic                          capture_done,
  input  logic [C_S_AXI_DATA_WIDTH-1:0] read_index,
  output logic [C_S_AXI_DATA_WIDTH-1:0] read_data,
  output logic [12:0]                   captured_pid,
  output logic [C_S_AXI_DATA_WIDTH-1:0] captured_count,
  output logic [C_S_AXI_DATA_WIDTH-1:0] resync_count,
  output logic [C_S_AXI_DATA_WIDTH-1:0] cc_error_count
);

  localparam int SLOT_W = (CAPTURE_PID_COUNT > 1) ? $clog2(CAPTURE_PID_COUNT) : 1;
  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_HUNT    = 2'd1;
  localparam logic [1:0] ST_CAPTURE = 2'd2;
  localparam logic [1:0] ST_DONE    = 2'd3;
  localparam logic [7:0] SYNC_BYTE  = 8'h47;
  localparam logic [7:0] LAST_BYTE  = 8'd187;

  logic [12:0]                   slot_pid [CAPTURE_PID_COUNT];
  logic [CAPTURE_PID_COUNT-1:0]  slot_en;
  logic [31:0]                   buf_mem [0:46];
  logic [1:0]                    state, state_nxt;
  logic [7:0]                    cnt, cnt_nxt;
  logic [7:0]                    wr_addr;
  logic                          wr_en, resync, finish, pid_hit;
  logic [4:0]                    hdr1;
  logic [12:0]                   rx_pid, cur_pid;
  logic                          slot_in_range;
  logic [SLOT_W-1:0]             slot_sel;
  logic                          unused_pid_bits;

  assign slot_in_range   = pid_index < CAPTURE_PID_COUNT;
  assign slot_sel        = pid_index[SLOT_W-1:0];
  assign unused_pid_bits = ^{pid[31:17], pid[15:13]};
  assign rx_pid          = {hdr1, ts.mpeg_data};
  assign capture_busy    = (state == ST_HUNT) || (state == ST_CAPTURE);
  assign capture_done    = (state == ST_DONE);

  always_comb begin
    pid_hit = 1'b0;
    for (int i = 0; i < CAPTURE_PID_COUNT; i++)
      if (slot_en[i] && (slot_pid[i] == rx_pid)) pid_hit = 1'b1;
  end

  always_comb begin
    out_pid = '0;
    if (slot_in_range) begin
      out_pid[12:0] = slot_pid[slot_sel];
      out_pid[16]   = slot_en[slot_sel];
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    wr_en     = 1'b0;
    wr_addr   = cnt;
    resync    = 1'b0;
    finish    = 1'b0;
    case (state)
      ST_IDLE: if (arm) state_nxt = ST_HUNT;
      ST_HUNT: begin
        if (ts.mpeg_valid && ts.mpeg_sync && (ts.mpeg_data == SYNC_BYTE)) begin
          wr_en     = 1'b1;
          wr_addr   = 8'd0;
          cnt_nxt   = 8'd1;
          state_nxt = ST_CAPTURE;
        end
      end
      ST_CAPTURE: begin
        if (ts.mpeg_valid) begin
          if (ts.mpeg_sync) begin
            // Sync inside a packet: the stream slipped, restart on this byte.
            resync = 1'b1;
            if (ts.mpeg_data == SYNC_BYTE) begin
              wr_en   = 1'b1;
              wr_addr = 8'd0;
              cnt_nxt = 8'd1;
            end else begin
              state_nxt = ST_HUNT;
            end
          end else begin
            wr_en   = 1'b1;
            cnt_nxt = cnt + 8'd1;
            if ((cnt == 8'd2) && !pid_hit) state_nxt = ST_HUNT;
            if (cnt == LAST_BYTE) begin
              state_nxt = ST_DONE;
              finish    = 1'b1;
            end
          end
        end
      end
      default: if (capture_ack) state_nxt = arm ? ST_HUNT : ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= ST_IDLE;
      cnt            <= '0;
      hdr1           <= '0;
      cur_pid        <= '0;
      slot_en        <= '0;
      captured_pid   <= '0;
      captured_count <= '0;
      resync_count   <= '0;
      read_data      <= '0;
      for (int i = 0; i < CAPTURE_PID_COUNT; i++) slot_pid[i] <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (update_pid_request && slot_in_range) begin
        slot_pid[slot_sel] <= pid[12:0];
        slot_en[slot_sel]  <= pid[16];
      end
      if (wr_en && (wr_addr == 8'd1)) hdr1 <= ts.mpeg_data[4:0];
      if (wr_en && (wr_addr == 8'd2)) cur_pid <= rx_pid;
      if (resync) resync_count <= resync_count + 1'b1;
      if (finish) begin
        captured_count <= captured_count + 1'b1;
        captured_pid   <= cur_pid;
      end
      read_data <= (read_index < 32'd47) ? buf_mem[read_index[5:0]] : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) buf_mem[wr_addr[7:2]][{wr_addr[1:0], 3'b000} +: 8] <= ts.mpeg_data;
  end

`ifdef TS_CAPTURE_CC_CHECK_EN
  logic [3:0]                    cc_cur, cc_prev;
  logic                          cc_seen;
  logic [C_S_AXI_DATA_WIDTH-1:0] cc_err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cc_cur   <= '0;
      cc_prev  <= '0;
      cc_seen  <= 1'b0;
      cc_err_q <= '0;
    end else begin
      if (wr_en && (wr_addr == 8'd3)) cc_cur <= ts.mpeg_data[3:0];
      if (finish) begin
        cc_prev <= cc_cur;
        cc_seen <= 1'b1;
        if (cc_seen && (cc_cur != cc_prev + 4'd1)) cc_err_q <= cc_err_q + 1'b1;
      end
    end
  end
  assign cc_error_count = cc_err_q;
`else
  assign cc_error_count = '0;
`endif

endmodule

// File: tb/tb_ts_pid_capture.sv
// Directed bench for ts_pid_capture: PID slot table vectors plus multi-packet capture sequences.
module tb_ts_pid_capture;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        update_pid_request = 1'b0;
  logic [31:0] pid_index = '0, pid = '0, out_pid;
  logic        arm = 1'b0, capture_ack = 1'b0, capture_busy, capture_done;
  logic [31:0] read_index = '0, read_data;
  logic [12:0] captured_pid;
  logic [31:0] captured_count, resync_count, cc_error_count;
  int          total = 0, bad = 0;

`ifdef TS_CAPTURE_CC_CHECK_EN
  localparam logic [31:0] CC_ON = 32'd1;
`else
  localparam logic [31:0] CC_ON = 32'd0;
`endif

  ts_pid_capture_if ts_if ();

  ts_pid_capture dut (
    .clk(clk), .rst(rst), .ts(ts_if.slave),
    .update_pid_request(update_pid_request), .pid_index(pid_index), .pid(pid), .out_pid(out_pid),
    .arm(arm), .capture_ack(capture_ack), .capture_busy(capture_busy), .capture_done(capture_done),
    .read_index(read_index), .read_data(read_data), .captured_pid(captured_pid),
    .captured_count(captured_count), .resync_count(resync_count), .cc_error_count(cc_error_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        upd;
    logic [31:0] idx;
    logic [31:0] val;
    logic [31:0] rd_idx;
    logic [31:0] exp;
  } vec_t;
  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] pkt_byte(input logic [12:0] p, input logic [3:0] cc, input int k);
    if (k == 0) return 8'h47;
    if (k == 1) return {3'b000, p[12:8]};
    if (k == 2) return p[7:0];
    if (k == 3) return {4'h1, cc};
    return k[7:0];
  endfunction

  task automatic send_byte(input logic [7:0] d, input logic s, input bit gap);
    ts_if.mpeg_data  = d;
    ts_if.mpeg_sync  = s;
    ts_if.mpeg_valid = 1'b1;
    tick();
    ts_if.mpeg_valid = 1'b0;
    ts_if.mpeg_sync  = 1'b0;
    if (gap) begin
      ts_if.mpeg_data = 8'hEE;
      ts_if.mpeg_sync = 1'b1;
      tick();
      ts_if.mpeg_sync = 1'b0;
    end
  endtask

  task automatic send_pkt(input logic [12:0] p, input logic [3:0] cc, input bit gap, input int nbytes);
    for (int k = 0; k < nbytes; k++) send_byte(pkt_byte(p, cc, k), k == 0, gap);
  endtask

  task automatic read_word(input logic [31:0] idx);
    read_index = idx;
    tick();
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, " busy"}, {31'd0, capture_busy}, 32'd0);
    check({tag, " done"}, {31'd0, capture_done}, 32'd0);
    check({tag, " captured_count"}, captured_count, 32'd0);
    check({tag, " resync_count"}, resync_count, 32'd0);
    check({tag, " cc_error_count"}, cc_error_count, 32'd0);
    check({tag, " captured_pid"}, {19'd0, captured_pid}, 32'd0);
    check({tag, " read_data"}, read_data, 32'd0);
    check({tag, " out_pid slot0"}, out_pid, 32'd0);
  endtask

  initial begin
    vecs[0] = '{1'b1, 32'd0,          32'h0001_0100, 32'd0, 32'h0001_0100};
    vecs[1] = '{1'b1, 32'd3,          32'hFFFF_FFFF, 32'd3, 32'h0001_1FFF};
    vecs[2] = '{1'b1, 32'd4,          32'h0001_0055, 32'd4, 32'h0000_0000};
    vecs[3] = '{1'b0, 32'd0,          32'h0001_1FFF, 32'd0, 32'h0001_0100};
    vecs[4] = '{1'b1, 32'd1,          32'h0000_0101, 32'd1, 32'h0000_0101};
    vecs[5] = '{1'b1, 32'd3,          32'h0000_0000, 32'd3, 32'h0000_0000};
    vecs[6] = '{1'b1, 32'h8000_0000,  32'h0001_0000, 32'd0, 32'h0001_0100};
    vecs[7] = '{1'b0, 32'd0,          32'h0000_0000, 32'd2, 32'h0000_0000};

    ts_if.mpeg_data  = 8'h00;
    ts_if.mpeg_valid = 1'b0;
    ts_if.mpeg_sync  = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    check_zero_outputs("reset");

    foreach (vecs[i]) begin
      update_pid_request = vecs[i].upd;
      pid_index          = vecs[i].idx;
      pid                = vecs[i].val;
      tick();
      update_pid_request = 1'b0;
      pid_index          = vecs[i].rd_idx;
      #1;
      check($sformatf("slot vec%0d", i), out_pid, vecs[i].exp);
    end

    // Gapless capture of PID 0x100 with CC 3.
    arm = 1'b1;
    tick();
    arm = 1'b0;
    check("armed busy", {31'd0, capture_busy}, 32'd1);
    send_pkt(13'h100, 4'd3, 1'b0, 188);
    check("A done", {31'd0, capture_done}, 32'd1);
    check("A busy", {31'd0, capture_busy}, 32'd0);
    check("A count", captured_count, 32'd1);
    check("A pid", {19'd0, captured_pid}, 32'h100);
    read_word(32'd1);  check("A word1", read_data, 32'h0706_0504);
    read_word(32'd0);  check("A word0", read_data, 32'h1300_0147);
    read_word(32'd46); check("A word46", read_data, 32'hBBBA_B9B8);
    read_word(32'd47); check("A word47", read_data, 32'd0);
    check("A cc_err", cc_error_count, 32'd0);

    // DONE freezes buffer and ignores stream, including sync bytes.
    send_byte(8'h47, 1'b1, 1'b0);
    send_byte(8'h99, 1'b0, 1'b0);
    read_word(32'd0);  check("frozen word0", read_data, 32'h1300_0147);
    check("frozen resync", resync_count, 32'd0);
    check("frozen done", {31'd0, capture_done}, 32'd1);

    capture_ack = 1'b1;
    tick();
    capture_ack = 1'b0;
    check("ack idle done", {31'd0, capture_done}, 32'd0);
    check("ack idle busy", {31'd0, capture_busy}, 32'd0);

    // Non-matching PID 0x101 (slot1 disabled) is dropped; gapped 0x100 packet with CC 5 follows.
    arm = 1'b1;
    tick();
    arm = 1'b0;
    send_pkt(13'h101, 4'd4, 1'b0, 188);
    check("B skip busy", {31'd0, capture_busy}, 32'd1);
    check("B skip count", captured_count, 32'd1);
    send_pkt(13'h100, 4'd5, 1'b1, 188);
    check("B done", {31'd0, capture_done}, 32'd1);
    check("B count", captured_count, 32'd2);
    check("B pid", {19'd0, captured_pid}, 32'h100);
    check("B cc_err", cc_error_count, CC_ON);
    read_word(32'd1);  check("B word1", read_data, 32'h0706_0504);
    read_word(32'd0);  check("B word0", read_data, 32'h1500_0147);
    read_word(32'd46); check("B word46", read_data, 32'hBBBA_B9B8);

    // Ack with re-arm goes straight back to HUNT.
    arm = 1'b1;
    capture_ack = 1'b1;
    tick();
    arm = 1'b0;
    capture_ack = 1'b0;
    check("rearm busy", {31'd0, capture_busy}, 32'd1);
    check("rearm done", {31'd0, capture_done}, 32'd0);

    // Resync at byte 100: new packet (CC 6) starts on that byte.
    send_pkt(13'h100, 4'd2, 1'b0, 100);
    check("C mid busy", {31'd0, capture_busy}, 32'd1);
    send_pkt(13'h100, 4'd6, 1'b0, 188);
    check("C resync", resync_count, 32'd1);
    check("C done", {31'd0, capture_done}, 32'd1);
    check("C count", captured_count, 32'd3);
    check("C cc_err", cc_error_count, CC_ON);
    read_word(32'd0);  check("C word0", read_data, 32'h1600_0147);

    // Reset mid-capture abandons the packet.
    arm = 1'b1;
    capture_ack = 1'b1;
    tick();
    arm = 1'b0;
    capture_ack = 1'b0;
    pid_index = 32'd0;
    send_pkt(13'h100, 4'd7, 1'b0, 50);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    check_zero_outputs("rst mid");
    send_pkt(13'h100, 4'd8, 1'b0, 188);
    check("post rst count", captured_count, 32'd0);
    check("post rst done", {31'd0, capture_done}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
